// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read-port register bank with optional zero register, write bypass
// and a one-entry-per-cycle clear sweep.
module register_bank_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             reg_write,
    input  logic [ADDR_WIDTH-1:0]            write_register,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_register,
    output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
    input  logic                             clear,
    output logic                             busy,
    output logic                             write_dropped
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_bank [DEPTH];
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_dropped;
    logic                  w_accept;

    assign w_accept = reg_write && r_state == IDLE && !(ZERO_REG != 0 && write_register == '0);

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = clear ? SWEEP : IDLE;
        else
            w_next = (&r_ptr) ? IDLE : SWEEP;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dropped <= reg_write && r_state == SWEEP;
            r_ptr     <= (r_state == SWEEP) ? r_ptr + 1'b1 : '0;
        end
    end

    // Writes and sweep are mutually exclusive: writes are only accepted in IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_bank[i] <= '0;
        end else if (r_state == SWEEP) begin
            r_bank[r_ptr] <= '0;
        end else if (w_accept) begin
            r_bank[write_register] <= write_data;
        end
    end

    assign busy          = (r_state == SWEEP);
    assign write_dropped = r_dropped;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        assign w_ra = read_register[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] =
            (ZERO_REG != 0 && w_ra == '0)                    ? '0 :
            (BYPASS != 0 && w_accept && w_ra == write_register) ? write_data :
                                                               r_bank[w_ra];
    end
endmodule
